// File: rtl/icb_sbus_arb.sv
// icb_sbus_arb: 2:1 ICB arbiter merging the core LSU and JTAG debug masters
// onto one system-bus slave port, one transaction in flight, with a watchdog.
module icb_sbus_arb #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int PRIO_JTAG = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              core_icb_cmd_valid,
    output logic              core_icb_cmd_ready,
    input  logic [AW-1:0]     core_icb_cmd_addr,
    input  logic              core_icb_cmd_read,
    input  logic [DW-1:0]     core_icb_cmd_wdata,
    input  logic [DW/8-1:0]   core_icb_cmd_wmask,
    output logic              core_icb_rsp_valid,
    input  logic              core_icb_rsp_ready,
    output logic              core_icb_rsp_err,
    output logic [DW-1:0]     core_icb_rsp_rdata,

    input  logic              jtag_icb_cmd_valid,
    output logic              jtag_icb_cmd_ready,
    input  logic [AW-1:0]     jtag_icb_cmd_addr,
    input  logic              jtag_icb_cmd_read,
    input  logic [DW-1:0]     jtag_icb_cmd_wdata,
    input  logic [DW/8-1:0]   jtag_icb_cmd_wmask,
    output logic              jtag_icb_rsp_valid,
    input  logic              jtag_icb_rsp_ready,
    output logic              jtag_icb_rsp_err,
    output logic [DW-1:0]     jtag_icb_rsp_rdata,

    output logic              s_icb_cmd_valid,
    input  logic              s_icb_cmd_ready,
    output logic [AW-1:0]     s_icb_cmd_addr,
    output logic              s_icb_cmd_read,
    output logic [DW-1:0]     s_icb_cmd_wdata,
    output logic [DW/8-1:0]   s_icb_cmd_wmask,
    input  logic              s_icb_rsp_valid,
    output logic              s_icb_rsp_ready,
    input  logic              s_icb_rsp_err,
    input  logic [DW-1:0]     s_icb_rsp_rdata,

    output logic              timeout_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMD  = 2'd1;
    localparam logic [1:0] S_RSP  = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [1:0]    state_q, state_d;
    logic          gnt_q, gnt_d;
    logic          last_gnt_q, last_gnt_d;
    logic          timeout_q, timeout_d;
    logic [WW-1:0] wdog_q, wdog_d;

    logic pick_jtag;
    logic sel_jtag;
    logic sel_cmd_valid;
    logic sel_rsp_ready;
    logic wdog_hit;

    // On a tie, PRIO_JTAG forces jtag; otherwise whoever was not served last.
    assign pick_jtag = jtag_icb_cmd_valid
                     & (~core_icb_cmd_valid | (PRIO_JTAG != 0) | ~last_gnt_q);

    assign sel_jtag      = gnt_q & (state_q != S_IDLE);
    assign sel_cmd_valid = gnt_q ? jtag_icb_cmd_valid : core_icb_cmd_valid;
    assign sel_rsp_ready = gnt_q ? jtag_icb_rsp_ready : core_icb_rsp_ready;
    assign wdog_hit      = (TIMEOUT != 0) && (wdog_q == WW'(TIMEOUT - 1));

    assign s_icb_cmd_addr  = sel_jtag ? jtag_icb_cmd_addr  : core_icb_cmd_addr;
    assign s_icb_cmd_read  = sel_jtag ? jtag_icb_cmd_read  : core_icb_cmd_read;
    assign s_icb_cmd_wdata = sel_jtag ? jtag_icb_cmd_wdata : core_icb_cmd_wdata;
    assign s_icb_cmd_wmask = sel_jtag ? jtag_icb_cmd_wmask : core_icb_cmd_wmask;
    assign timeout_o       = timeout_q;

    always_comb begin
        state_d            = state_q;
        gnt_d              = gnt_q;
        last_gnt_d         = last_gnt_q;
        wdog_d             = wdog_q;
        timeout_d          = 1'b0;
        s_icb_cmd_valid    = 1'b0;
        s_icb_rsp_ready    = 1'b0;
        core_icb_cmd_ready = 1'b0;
        jtag_icb_cmd_ready = 1'b0;
        core_icb_rsp_valid = 1'b0;
        core_icb_rsp_err   = 1'b0;
        core_icb_rsp_rdata = '0;
        jtag_icb_rsp_valid = 1'b0;
        jtag_icb_rsp_err   = 1'b0;
        jtag_icb_rsp_rdata = '0;
        unique case (state_q)
            S_IDLE: begin
                // Stray or late responses are swallowed here.
                s_icb_rsp_ready = 1'b1;
                if (core_icb_cmd_valid | jtag_icb_cmd_valid) begin
                    gnt_d   = pick_jtag;
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                s_icb_cmd_valid    = sel_cmd_valid;
                core_icb_cmd_ready = ~gnt_q & s_icb_cmd_ready;
                jtag_icb_cmd_ready = gnt_q & s_icb_cmd_ready;
                if (!sel_cmd_valid) begin
                    state_d = S_IDLE;
                end else if (s_icb_cmd_ready) begin
                    last_gnt_d = gnt_q;
                    wdog_d     = '0;
                    state_d    = S_RSP;
                end
            end
            S_RSP: begin
                s_icb_rsp_ready = sel_rsp_ready;
                if (gnt_q) begin
                    jtag_icb_rsp_valid = s_icb_rsp_valid;
                    jtag_icb_rsp_err   = s_icb_rsp_err;
                    jtag_icb_rsp_rdata = s_icb_rsp_rdata;
                end else begin
                    core_icb_rsp_valid = s_icb_rsp_valid;
                    core_icb_rsp_err   = s_icb_rsp_err;
                    core_icb_rsp_rdata = s_icb_rsp_rdata;
                end
                if (s_icb_rsp_valid) begin
                    if (sel_rsp_ready) state_d = S_IDLE;
                end else if (wdog_hit) begin
                    timeout_d = 1'b1;
                    state_d   = S_ERR;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            S_ERR: begin
                if (gnt_q) begin
                    jtag_icb_rsp_valid = 1'b1;
                    jtag_icb_rsp_err   = 1'b1;
                end else begin
                    core_icb_rsp_valid = 1'b1;
                    core_icb_rsp_err   = 1'b1;
                end
                if (sel_rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            wdog_q     <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            wdog_q     <= wdog_d;
            timeout_q  <= timeout_d;
        end
    end

endmodule

// File: tb/tb_icb_sbus_arb.sv
// tb_icb_sbus_arb: random and directed traffic on two arbiter instances
// (jtag priority with watchdog 8, round-robin with watchdog off).
module tb_icb_sbus_arb;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        cv[2][2], cr[2][2], crd[2][2], rv[2][2], rr[2][2], re[2][2];
    logic [31:0] ca[2][2], cw[2][2], rd[2][2];
    logic [3:0]  cm[2][2];
    logic        sv[2], sr[2], sread[2], srv[2], srr[2], sre[2], tmo[2];
    logic [31:0] sa[2], sw[2], srd[2];
    logic [3:0]  sm[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        icb_sbus_arb #(
            .AW(32), .DW(32),
            .PRIO_JTAG((g == 0) ? 1 : 0),
            .TIMEOUT((g == 0) ? 8 : 0)
        ) u_dut (
            .clk(clk), .rst_n(rst_n),
            .core_icb_cmd_valid(cv[g][0]), .core_icb_cmd_ready(cr[g][0]),
            .core_icb_cmd_addr(ca[g][0]), .core_icb_cmd_read(crd[g][0]),
            .core_icb_cmd_wdata(cw[g][0]), .core_icb_cmd_wmask(cm[g][0]),
            .core_icb_rsp_valid(rv[g][0]), .core_icb_rsp_ready(rr[g][0]),
            .core_icb_rsp_err(re[g][0]), .core_icb_rsp_rdata(rd[g][0]),
            .jtag_icb_cmd_valid(cv[g][1]), .jtag_icb_cmd_ready(cr[g][1]),
            .jtag_icb_cmd_addr(ca[g][1]), .jtag_icb_cmd_read(crd[g][1]),
            .jtag_icb_cmd_wdata(cw[g][1]), .jtag_icb_cmd_wmask(cm[g][1]),
            .jtag_icb_rsp_valid(rv[g][1]), .jtag_icb_rsp_ready(rr[g][1]),
            .jtag_icb_rsp_err(re[g][1]), .jtag_icb_rsp_rdata(rd[g][1]),
            .s_icb_cmd_valid(sv[g]), .s_icb_cmd_ready(sr[g]),
            .s_icb_cmd_addr(sa[g]), .s_icb_cmd_read(sread[g]),
            .s_icb_cmd_wdata(sw[g]), .s_icb_cmd_wmask(sm[g]),
            .s_icb_rsp_valid(srv[g]), .s_icb_rsp_ready(srr[g]),
            .s_icb_rsp_err(sre[g]), .s_icb_rsp_rdata(srd[g]),
            .timeout_o(tmo[g])
        );
    end

    int n_chk = 0;
    int n_err = 0;
    int d = 0;

    // master request model
    logic        has_req[2];
    int          remaining[2];
    logic [31:0] q_addr[2], q_wdata[2];
    logic        q_read[2];
    logic [3:0]  q_wmask[2];

    // knobs
    int req_pct, rdy_pct, rr_pct, max_dly, fix_dly, lo_left;
    bit silent, stray, use_fix;
    logic [31:0] fix_data;

    // transaction-level reference
    bit t_on, t_issued, t_expired, tmo_exp;
    int t_own, t_age, last_own;
    bit s_pend;
    int s_dly;
    logic [31:0] s_data;
    logic s_err;

    // observations of the DUT
    int cyc, tmo_cnt, stall_cnt;
    logic sv_prev;
    int obs_own[$], obs_start[$], obs_done[$];
    logic [31:0] obs_addr[$];
    logic [31:0] got_rd[2];
    logic got_err[2];

    function automatic int prio_of(int x);
        return (x == 0) ? 1 : 0;
    endfunction

    function automatic int tmo_of(int x);
        return (x == 0) ? 8 : 0;
    endfunction

    function automatic logic [8:0] ctl_of(int x);
        return {sv[x], cr[x][0], cr[x][1], srr[x], rv[x][0], rv[x][1],
                re[x][0], re[x][1], tmo[x]};
    endfunction

    task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int x = 0; x < 2; x++) begin
            sr[x] = 0; srv[x] = 0; sre[x] = 0; srd[x] = '0;
            for (int m = 0; m < 2; m++) begin
                cv[x][m] = 0; crd[x][m] = 0; rr[x][m] = 0;
                ca[x][m] = '0; cw[x][m] = '0; cm[x][m] = '0;
            end
        end
        for (int m = 0; m < 2; m++) begin
            has_req[m] = 0; remaining[m] = 0;
            q_addr[m] = '0; q_wdata[m] = '0; q_read[m] = 0; q_wmask[m] = '0;
            got_rd[m] = '0; got_err[m] = 0;
        end
        req_pct = 100; rdy_pct = 100; rr_pct = 100; max_dly = 3;
        fix_dly = 0; lo_left = 0; silent = 0; stray = 0; use_fix = 0;
        fix_data = '0;
        t_on = 0; t_issued = 0; t_expired = 0; tmo_exp = 0;
        t_own = 0; t_age = 0; last_own = 1;
        s_pend = 0; s_dly = 0; s_data = '0; s_err = 0;
        tmo_cnt = 0; stall_cnt = 0; sv_prev = 0;
        obs_own.delete(); obs_start.delete();
        obs_done.delete(); obs_addr.delete();
    endtask

    task automatic do_reset(int nd);
        @(negedge clk);
        d = nd;
        rst_n = 0;
        model_clear();
        #1;
        check("rst_ctl", ctl_of(d), 9'b000100000);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic set_req(int m, logic [31:0] a, logic rdf, logic [3:0] wm);
        has_req[m] = 1;
        remaining[m] = 1;
        q_addr[m] = a;
        q_read[m] = rdf;
        q_wdata[m] = $urandom;
        q_wmask[m] = wm;
    endtask

    task automatic step();
        logic        e_sv, e_srr;
        logic        e_cr[2], e_rv[2], e_re[2];
        logic [31:0] e_rd[2];
        int o, sel;
        @(negedge clk);
        cyc++;
        for (int m = 0; m < 2; m++) begin
            if (!has_req[m] && remaining[m] > 0
                && $urandom_range(99) < req_pct) begin
                has_req[m] = 1;
                q_addr[m]  = $urandom;
                q_read[m]  = 1'($urandom_range(1));
                q_wdata[m] = $urandom;
                q_wmask[m] = 4'($urandom_range(15));
            end
            cv[d][m]  = has_req[m];
            ca[d][m]  = q_addr[m];
            crd[d][m] = q_read[m];
            cw[d][m]  = q_wdata[m];
            cm[d][m]  = q_wmask[m];
            rr[d][m]  = ($urandom_range(99) < rr_pct);
        end
        sr[d]  = (lo_left > 0) ? 1'b0 : ($urandom_range(99) < rdy_pct);
        srv[d] = (s_pend && s_dly == 0) || stray;
        srd[d] = s_pend ? s_data : $urandom;
        sre[d] = s_pend ? s_err : 1'b0;
        #1;
        o = t_own;
        sel = 0;
        e_sv = 0; e_srr = 0;
        for (int m = 0; m < 2; m++) begin
            e_cr[m] = 0; e_rv[m] = 0; e_re[m] = 0; e_rd[m] = '0;
        end
        if (!t_on) begin
            e_srr = 1;
        end else if (!t_issued) begin
            e_sv = has_req[o];
            e_cr[o] = sr[d];
            sel = o;
        end else if (!t_expired) begin
            e_rv[o] = srv[d];
            e_re[o] = sre[d];
            e_rd[o] = srd[d];
            e_srr = rr[d][o];
        end else begin
            e_rv[o] = 1;
            e_re[o] = 1;
        end
        check("ctl", ctl_of(d), {e_sv, e_cr[0], e_cr[1], e_srr, e_rv[0],
                                 e_rv[1], e_re[0], e_re[1], tmo_exp});
        check("rd_core", rd[d][0], e_rd[0]);
        check("rd_jtag", rd[d][1], e_rd[1]);
        if (!t_on || !t_issued)
            check("s_cmd", {sa[d], sw[d], sm[d], sread[d]},
                  {q_addr[sel], q_wdata[sel], q_wmask[sel], q_read[sel]});

        if (tmo[d]) tmo_cnt++;
        if (sv[d] && !sv_prev) obs_start.push_back(cyc);
        if (sv[d] && !sr[d]) stall_cnt++;
        if (sv[d] && sr[d]) begin
            obs_own.push_back(cr[d][1] ? 1 : 0);
            obs_addr.push_back(sa[d]);
        end
        for (int m = 0; m < 2; m++) begin
            if (rv[d][m] && rr[d][m]) begin
                got_rd[m] = rd[d][m];
                got_err[m] = re[d][m];
                obs_done.push_back(cyc);
            end
        end
        sv_prev = sv[d];

        tmo_exp = 0;
        if (s_pend && s_dly > 0) s_dly--;
        if (!t_on) begin
            if (has_req[0] || has_req[1]) begin
                t_on = 1; t_issued = 0; t_expired = 0;
                if (has_req[0] && has_req[1])
                    t_own = (prio_of(d) != 0) ? 1 : ((last_own == 1) ? 0 : 1);
                else
                    t_own = has_req[1] ? 1 : 0;
            end
        end else if (!t_issued) begin
            if (lo_left > 0) lo_left--;
            if (sr[d]) begin
                t_issued = 1; t_age = 0; last_own = o;
                has_req[o] = 0; remaining[o]--;
                if (!silent) begin
                    s_pend = 1;
                    s_dly  = use_fix ? fix_dly : $urandom_range(max_dly);
                    s_data = use_fix ? fix_data : $urandom;
                    s_err  = use_fix ? 1'b0 : ($urandom_range(99) < 10);
                end
            end
        end else if (!t_expired) begin
            if (srv[d] && rr[d][o]) begin
                t_on = 0;
                s_pend = 0;
            end else if (!srv[d]) begin
                if (tmo_of(d) != 0 && t_age == tmo_of(d) - 1) begin
                    t_expired = 1;
                    tmo_exp = 1;
                end else begin
                    t_age++;
                end
            end
        end else if (rr[d][o]) begin
            t_on = 0;
        end
    endtask

    task automatic run_until_done(int max);
        int n = 0;
        while ((remaining[0] > 0 || remaining[1] > 0 || t_on) && n < max) begin
            step();
            n++;
        end
        check("bound_done", {t_on, remaining[0] > 0, remaining[1] > 0}, 3'b000);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running");
        $fatal(1, "hung");
    end

    initial begin
        rst_n = 1;
        cyc = 0;
        model_clear();

        // single core read, response 2 cycles after the command
        do_reset(0);
        set_req(0, 32'h0000_1000, 1'b1, 4'h0);
        use_fix = 1; fix_dly = 2; fix_data = 32'hDEAD_BEEF;
        run_until_done(50);
        check("t1_rdata", got_rd[0], 32'hDEAD_BEEF);
        check("t1_err", got_err[0], 1'b0);

        // simultaneous requests, jtag priority
        do_reset(0);
        set_req(0, 32'h0000_3000, 1'b1, 4'h0);
        set_req(1, 32'h2000_0004, 1'b0, 4'b0011);
        run_until_done(60);
        check("t2_n", obs_own.size(), 2);
        if (obs_own.size() == 2 && obs_done.size() == 2 && obs_start.size() == 2) begin
            check("t2_first", obs_own[0], 1);
            check("t2_second", obs_own[1], 0);
            check("t2_addr", obs_addr[0], 32'h2000_0004);
            check("t2_gap", obs_start[1] - obs_done[0], 2);
        end

        // round-robin under continuous requests
        do_reset(1);
        remaining[0] = 2; remaining[1] = 2;
        run_until_done(100);
        check("t3_n", obs_own.size(), 4);
        if (obs_own.size() == 4)
            for (int i = 0; i < 4; i++) check("t3_order", obs_own[i], i % 2);

        // slave back-pressure for five cycles
        do_reset(0);
        set_req(0, 32'h0000_4000, 1'b0, 4'hf);
        lo_left = 5;
        run_until_done(60);
        check("t4_stall", stall_cnt, 5);
        check("t4_issued", obs_own.size(), 1);

        // watchdog fires, late response absorbed, next request completes
        do_reset(0);
        set_req(0, 32'h0000_5000, 1'b1, 4'h0);
        silent = 1;
        run_until_done(60);
        check("t5_tmo_cnt", tmo_cnt, 1);
        check("t5_err", got_err[0], 1'b1);
        check("t5_rdata", got_rd[0], 32'h0);
        silent = 0; stray = 1;
        step();
        stray = 0;
        set_req(1, 32'h0000_6000, 1'b1, 4'h0);
        use_fix = 1; fix_dly = 1; fix_data = 32'h1234_5678;
        run_until_done(60);
        check("t5_next_rdata", got_rd[1], 32'h1234_5678);
        check("t5_next_err", got_err[1], 1'b0);

        // watchdog disabled, then asynchronous reset while waiting
        do_reset(1);
        set_req(0, 32'h0000_7000, 1'b1, 4'h0);
        silent = 1; rr_pct = 0;
        for (int i = 0; i < 24; i++) step();
        check("t6_no_tmo", tmo_cnt, 0);
        check("t6_in_rsp", {t_on, t_issued}, 2'b11);
        #2;
        rst_n = 0;
        #1;
        check("t6_async", ctl_of(1), 9'b000100000);
        model_clear();
        @(negedge clk);
        rst_n = 1;
        remaining[0] = 1; remaining[1] = 1;
        run_until_done(60);
        check("t6_tie_n", obs_own.size(), 2);
        if (obs_own.size() > 0) check("t6_tie_core", obs_own[0], 0);

        // randomized traffic on both instances
        for (int x = 0; x < 2; x++) begin
            do_reset(x);
            remaining[0] = 25; remaining[1] = 25;
            req_pct = 30; rdy_pct = 60; rr_pct = 70; max_dly = 3;
            run_until_done(4000);
            check("rand_count", obs_own.size(), 50);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
